// File: rtl/hazard_unit_sb.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and scoreboard
// stalls, branch flushes, one iterative multi-cycle unit and a saturating stall counter.

// Forwarding select for one Execute source operand; M has priority over W.
module hazard_fwd_lane #(
    parameter int RW = 4
) (
    input  logic [RW-1:0] ra_e,
    input  logic [RW-1:0] wa3_m,
    input  logic [RW-1:0] wa3_w,
    input  logic          reg_write_m,
    input  logic          reg_write_w,
    output logic [1:0]    fwd
);
    always_comb begin
        fwd = 2'b00;
        if (reg_write_m && (ra_e == wa3_m))
            fwd = 2'b10;
        else if (reg_write_w && (ra_e == wa3_w))
            fwd = 2'b01;
    end
endmodule

// Hazard detection for one Decode source operand.
module hazard_src_lane #(
    parameter int NREG = 16,
    parameter int RW   = 4
) (
    input  logic [RW-1:0]   ra_d,
    input  logic [RW-1:0]   wa3_e,
    input  logic [NREG-1:0] pending,
    input  logic            mul_wb,
    input  logic [RW-1:0]   mul_wa,
    input  logic            mul_start,
    output logic            ldr_hit,
    output logic            scb_hit
);
    logic wb_bypass;

    // The regfile writes on the falling edge, so the write-back cycle itself
    // already delivers the multiply result to Decode.
    assign wb_bypass = mul_wb & (mul_wa == ra_d);
    assign ldr_hit   = (ra_d == wa3_e);
    assign scb_hit   = (pending[ra_d] & ~wb_bypass) | (mul_start & (wa3_e == ra_d));
endmodule

module hazard_unit_sb #(
    parameter int NREG    = 16,
    parameter int RW      = $clog2(NREG),
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RW-1:0]    RA1D,
    input  logic [RW-1:0]    RA2D,
    input  logic [RW-1:0]    RA1E,
    input  logic [RW-1:0]    RA2E,
    input  logic [RW-1:0]    WA3E,
    input  logic [RW-1:0]    WA3M,
    input  logic [RW-1:0]    WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             IsMulD,
    input  logic             MulStartE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulBusy,
    output logic             MulWbW,
    output logic [RW-1:0]    MulWA,
    output logic [CNT_W-1:0] StallCount
);
    localparam int NSRC = 2;
    localparam int CD_W = 4;

    logic [NSRC-1:0][RW-1:0] ra_e, ra_d;
    logic [NSRC-1:0][1:0]    fwd;
    logic [NSRC-1:0]         ldr_hit, scb_hit;

    logic [NREG-1:0] pending, pending_nxt;
    logic [CD_W-1:0] countdown;
    logic            mul_accept;
    logic            ldr_stall, scb_stall, mul_stall, stall, pc_wr_pending;

    assign ra_e = {RA2E, RA1E};
    assign ra_d = {RA2D, RA1D};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_fwd_lane #(.RW(RW)) u_fwd (
            .ra_e        (ra_e[i]),
            .wa3_m       (WA3M),
            .wa3_w       (WA3W),
            .reg_write_m (RegWriteM),
            .reg_write_w (RegWriteW),
            .fwd         (fwd[i])
        );

        hazard_src_lane #(.NREG(NREG), .RW(RW)) u_src (
            .ra_d      (ra_d[i]),
            .wa3_e     (WA3E),
            .pending   (pending),
            .mul_wb    (MulWbW),
            .mul_wa    (MulWA),
            .mul_start (MulStartE),
            .ldr_hit   (ldr_hit[i]),
            .scb_hit   (scb_hit[i])
        );
    end

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    assign ldr_stall     = MemtoRegE & RegWriteE & (|ldr_hit);
    assign scb_stall     = |scb_hit;
    assign mul_stall     = IsMulD & ((MulBusy & ~MulWbW) | MulStartE);
    assign stall         = ldr_stall | scb_stall | mul_stall;
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    assign StallF = stall | pc_wr_pending;
    assign StallD = stall;
    assign FlushE = stall | BranchTakenE;
    assign FlushD = pc_wr_pending | PCSrcW | BranchTakenE;

    // A start is taken when idle or in the write-back cycle; a start while
    // busy otherwise is illegal and dropped.
    assign mul_accept = MulStartE & (~MulBusy | MulWbW);

    // Clear the retiring register before setting the new one so a
    // back-to-back op to the same register stays pending.
    always_comb begin
        pending_nxt = pending;
        if (MulWbW)
            pending_nxt[MulWA] = 1'b0;
        if (mul_accept)
            pending_nxt[WA3E] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            countdown <= '0;
            MulBusy   <= 1'b0;
            MulWbW    <= 1'b0;
            MulWA     <= '0;
        end else begin
            pending <= pending_nxt;
            if (mul_accept) begin
                MulBusy   <= 1'b1;
                MulWbW    <= 1'b0;
                MulWA     <= WA3E;
                countdown <= CD_W'(MUL_LAT - 1);
            end else if (MulWbW) begin
                MulBusy <= 1'b0;
                MulWbW  <= 1'b0;
            end else if (MulBusy) begin
                // Exhausted countdown fires the write-back MUL_LAT edges after start.
                if (countdown == '0)
                    MulWbW <= 1'b1;
                else
                    countdown <= countdown - CD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCount <= '0;
        else if (StallD && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_unit_sb.sv
// Bench for hazard_unit_sb: combinational vector table plus multi-cycle
// sequences checked through expectation queues.
module tb_hazard_unit_sb;
    localparam int NREG = 16, RW = 4, MUL_LAT = 4, CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [RW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, IsMulD, MulStartE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic StallF, StallD, FlushD, FlushE, MulBusy, MulWbW;
    logic [1:0] ForwardAE, ForwardBE;
    logic [RW-1:0] MulWA;
    logic [CNT_W-1:0] StallCount;

    hazard_unit_sb #(.NREG(NREG), .RW(RW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .IsMulD(IsMulD), .MulStartE(MulStartE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulBusy(MulBusy), .MulWbW(MulWbW), .MulWA(MulWA), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic rwe, rwm, rww, mte, pcd, pce, pcm, pcw, bte;
        logic [1:0] fa, fb;
        logic sf, sd, fd, fe;
    } vec_t;

    typedef struct packed {
        logic busy, wb;
        logic [3:0] wa;
        logic sd;
    } mexp_t;

    vec_t  vecs[$];
    vec_t  exq[$];
    mexp_t mq[$];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always @(posedge clk)
        if (rst_n && MulStartE && MulBusy && !MulWbW)
            $error("illegal MulStartE while multiplier busy");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0; WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; IsMulD = 0; MulStartE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww; MemtoRegE = v.mte;
        PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw; BranchTakenE = v.bte;
        IsMulD = 0; MulStartE = 0;
    endtask

    // Inputs for this cycle are already driven; expectations are queued, then
    // popped and compared mid-cycle.
    task automatic mstep(input string tag, input logic busy, input logic wb,
                         input logic [3:0] wa, input logic sd);
        mexp_t e;
        mq.push_back('{busy: busy, wb: wb, wa: wa, sd: sd});
        @(negedge clk);
        e = mq.pop_front();
        chk({tag, " MulBusy"}, 32'(MulBusy), 32'(e.busy));
        chk({tag, " MulWbW"}, 32'(MulWbW), 32'(e.wb));
        chk({tag, " MulWA"}, 32'(MulWA), 32'(e.wa));
        chk({tag, " StallD"}, 32'(StallD), 32'(e.sd));
        if (e.sd) exp_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v, e;

        // Forwarding, branch and load-use vectors (multiplier idle, no pending regs)
        v = '0; v.ra1e = 3; v.wa3m = 3; v.rwm = 1; v.wa3w = 3; v.rww = 1; v.ra2e = 5; v.fa = 2'b10; vecs.push_back(v);
        v = '0; v.ra1e = 3; v.wa3m = 3; v.wa3w = 3; v.rww = 1; v.ra2e = 5; v.fa = 2'b01; vecs.push_back(v);
        v = '0; v.ra1e = 2; v.wa3w = 2; v.rww = 1; v.ra2e = 9; v.wa3m = 9; v.rwm = 1; v.fa = 2'b01; v.fb = 2'b10; vecs.push_back(v);
        v = '0; v.ra1e = 4; v.ra2e = 4; v.wa3m = 4; v.wa3w = 4; vecs.push_back(v);
        v = '0; v.ra1e = 6; v.ra2e = 6; v.wa3m = 6; v.rwm = 1; v.fa = 2'b10; v.fb = 2'b10; vecs.push_back(v);
        v = '0; v.pce = 1; v.sf = 1; v.fd = 1; vecs.push_back(v);
        v = '0; v.pcd = 1; v.sf = 1; v.fd = 1; vecs.push_back(v);
        v = '0; v.pcm = 1; v.sf = 1; v.fd = 1; vecs.push_back(v);
        v = '0; v.bte = 1; v.fd = 1; v.fe = 1; vecs.push_back(v);
        v = '0; v.pcw = 1; v.fd = 1; vecs.push_back(v);
        v = '0; v.mte = 1; v.wa3e = 4; v.ra2d = 4; vecs.push_back(v);
        v = '0; v.mte = 1; v.rwe = 1; v.wa3e = 8; v.ra1d = 8; v.sf = 1; v.sd = 1; v.fe = 1; vecs.push_back(v);
        v = '0; v.mte = 1; v.rwe = 1; v.wa3e = 8; v.ra1d = 1; v.ra2d = 2; vecs.push_back(v);
        v = '0; v.rwe = 1; v.wa3e = 8; v.ra1d = 8; vecs.push_back(v);

        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset MulBusy", 32'(MulBusy), 0);
        chk("reset MulWbW", 32'(MulWbW), 0);
        chk("reset MulWA", 32'(MulWA), 0);
        chk("reset StallCount", 32'(StallCount), 0);
        chk("reset StallD", 32'(StallD), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use: one stall cycle, counter 0 -> 1
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4; RA2D = 4;
        @(negedge clk);
        chk("ldr StallF", 32'(StallF), 1);
        chk("ldr StallD", 32'(StallD), 1);
        chk("ldr FlushE", 32'(FlushE), 1);
        chk("ldr count before", 32'(StallCount), 0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("ldr StallD after", 32'(StallD), 0);
        chk("ldr count after", 32'(StallCount), 1);
        exp_cnt = 1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            exq.push_back(vecs[i]);
            @(negedge clk);
            e = exq.pop_front();
            chk($sformatf("vec%0d ForwardAE", i), 32'(ForwardAE), 32'(e.fa));
            chk($sformatf("vec%0d ForwardBE", i), 32'(ForwardBE), 32'(e.fb));
            chk($sformatf("vec%0d StallF", i), 32'(StallF), 32'(e.sf));
            chk($sformatf("vec%0d StallD", i), 32'(StallD), 32'(e.sd));
            chk($sformatf("vec%0d FlushD", i), 32'(FlushD), 32'(e.fd));
            chk($sformatf("vec%0d FlushE", i), 32'(FlushE), 32'(e.fe));
            if (e.sd) exp_cnt++;
            @(posedge clk); #1;
        end
        idle();
        chk("table StallCount", 32'(StallCount), 32'(exp_cnt));

        // Multiply latency: start to r7, RA1D=7 waits until the write-back cycle
        MulStartE = 1; WA3E = 7; RA1D = 7;
        mstep("lat pre", 0, 0, 0, 1);
        MulStartE = 0; WA3E = 0;
        for (int c = 0; c < MUL_LAT; c++) mstep($sformatf("lat c%0d", c), 1, 0, 7, 1);
        mstep("lat wb", 1, 1, 7, 0);
        mstep("lat done", 0, 0, 7, 0);
        chk("lat StallCount", 32'(StallCount), 32'(exp_cnt));

        // Structural stall, then back-to-back ops to r2 with overlap in the wb cycle
        idle();
        MulStartE = 1; WA3E = 5; IsMulD = 1;
        mstep("st pre", 0, 0, 7, 1);
        MulStartE = 0; WA3E = 0;
        for (int c = 0; c < MUL_LAT; c++) mstep($sformatf("st c%0d", c), 1, 0, 5, 1);
        RA1D = 5;
        mstep("st wb", 1, 1, 5, 0);
        IsMulD = 0; MulStartE = 1; WA3E = 2;
        mstep("b2b issue", 0, 0, 5, 0);
        MulStartE = 0; WA3E = 0; RA2D = 2;
        for (int c = 0; c < MUL_LAT; c++) mstep($sformatf("b2b c%0d", c), 1, 0, 2, 1);
        RA1D = 0; RA2D = 0; MulStartE = 1; WA3E = 2;
        mstep("b2b wb+start", 1, 1, 2, 0);
        MulStartE = 0; WA3E = 0; RA2D = 2;
        for (int c = 0; c < MUL_LAT; c++) mstep($sformatf("same c%0d", c), 1, 0, 2, 1);
        mstep("same wb", 1, 1, 2, 0);
        mstep("same done", 0, 0, 2, 0);
        chk("mul StallCount", 32'(StallCount), 32'(exp_cnt));

        // Reset with an op in flight
        idle();
        MulStartE = 1; WA3E = 9; RA1D = 9;
        mstep("rst pre", 0, 0, 2, 1);
        MulStartE = 0; WA3E = 0;
        mstep("rst c0", 1, 0, 9, 1);
        rst_n = 1'b0;
        #1;
        chk("rst MulBusy", 32'(MulBusy), 0);
        chk("rst StallD", 32'(StallD), 0);
        chk("rst StallCount", 32'(StallCount), 0);
        chk("rst MulWA", 32'(MulWA), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
        for (int c = 0; c < MUL_LAT + 2; c++) mstep($sformatf("post rst c%0d", c), 0, 0, 0, 0);

        // Counter saturation
        MemtoRegE = 1; RegWriteE = 1; WA3E = 3; RA1D = 3;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat fffe", 32'(StallCount), 32'h0000_fffe);
        @(posedge clk); #1;
        chk("sat ffff", 32'(StallCount), 32'h0000_ffff);
        repeat (3) @(posedge clk);
        #1;
        chk("sat hold", 32'(StallCount), 32'h0000_ffff);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
